// File: rtl/lab5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab5_pkg
// Description : Shared sizes and FSM encoding for the Lab5RAM FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lab5_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 2 ** ADDR_W;

  localparam int STATE_W = 1;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE    = 1'b0;
  localparam state_t RD_WAIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Wrapping address counter with increment enable.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr
  import lab5_pkg::*;
#(
  parameter int WIDTH = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  // Power-of-two depth: natural overflow gives the 63->0 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + WIDTH'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : Turns the 64x8 single-port Lab5RAM into a valid/ready FIFO
//               with a one-entry output register (65 entries total).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
  parameter int DATA_W = lab5_pkg::DATA_W,
  parameter int ADDR_W = lab5_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  import lab5_pkg::*;

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam int              CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_count;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;

  logic                w_rd_issue;
  logic                w_capture;
  logic                w_in_ready;
  logic                w_wr_fire;
  logic [ADDR_W-1:0]   w_wr_ptr;
  logic [ADDR_W-1:0]   w_rd_ptr;

  // ---------------------------------------------------------------- pointers
  fifo_ptr #(.WIDTH(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr_fire),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.WIDTH(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_issue),
    .o_ptr (w_rd_ptr)
  );

  // ------------------------------------------------------------ FSM: state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------- FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_rd_issue) w_next_state = RD_WAIT;
      RD_WAIT: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ----------------------------------------------------------- FSM: outputs
  // Reads take the port whenever the output register is (or is about to be)
  // free; since a read always spends one cycle in RD_WAIT, writes still get
  // at least every other cycle.
  always_comb begin
    w_rd_issue = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      IDLE:    w_rd_issue = !rst && (r_count != '0) && (!r_out_valid || out_ready);
      RD_WAIT: w_capture  = 1'b1;
      default: ;
    endcase
  end

  assign w_in_ready = !rst && (r_count < c_depth) && !w_rd_issue;
  assign w_wr_fire  = in_valid && w_in_ready;

  // --------------------------------------------------------------- RAM port
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_in   = '0;
    if (w_rd_issue) begin
      ram_cs   = 1'b1;
      ram_addr = w_rd_ptr;
    end else if (w_wr_fire) begin
      ram_cs   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = w_wr_ptr;
      ram_in   = in_data;
    end
  end

  // ------------------------------------------------------------- occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_rd_issue) begin
      r_count <= r_count - CNT_W'(1);
    end else if (w_wr_fire) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // ------------------------------------------------------- output register
  // A capture can never meet a pop: in RD_WAIT the register is always empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_data  <= ram_q;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign level     = r_count + CNT_W'(r_out_valid);

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_fifo_ctrl
// Description : Self-checking bench for ram_fifo_ctrl with a Lab5RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [6:0] level;
  logic [7:0] ram_in;
  logic [5:0] ram_addr;
  logic       ram_cs;
  logic       ram_we;
  logic [7:0] ram_q;

  logic [7:0] mem [64];

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model [$];
  int         wr_cnt = 0;
  logic       acc, popd;
  logic       s_rdy, s_cs, s_we, s_ov;
  logic [5:0] s_addr;
  logic [7:0] s_od;
  logic [6:0] s_level;

  ram_fifo_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ram_in    (ram_in),
    .ram_addr  (ram_addr),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  // Lab5RAM: synchronous write, registered read data.
  always @(posedge clk) begin
    if (ram_cs && ram_we)  mem[ram_addr] <= ram_in;
    if (ram_cs && !ram_we) ram_q <= mem[ram_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample, update the reference queue, advance.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    s_rdy = in_ready; s_cs = ram_cs; s_we = ram_we; s_addr = ram_addr;
    s_ov = out_valid; s_od = out_data; s_level = level;
    acc  = iv && in_ready;
    popd = out_valid && ordy;
    chk("level_range", 32'((int'(level) == model.size()) || (int'(level) + 1 == model.size())), 1);
    chk("we_vs_accept", ram_we, acc);
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ram_cs", ram_cs, 0);
    end
    if (model.size() >= 65) chk("full_in_ready", in_ready, 0);
    if (acc) begin
      chk("wr_cs", ram_cs, 1);
      chk("wr_addr", ram_addr, 32'(wr_cnt % 64));
      chk("wr_data", ram_in, id);
      model.push_back(id);
      wr_cnt++;
    end
    if (popd) begin
      if (model.size() == 0) begin
        chk("pop_when_empty", out_valid, 0);
      end else begin
        chk("pop_data", out_data, model[0]);
        void'(model.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_we", ram_we, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    wr_cnt = 0;
    #1;
    chk("reset_level", level, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
  endtask

  // Pop everything with out_ready held high; pops may never be back to back.
  task automatic drain(input string tag, output int pops);
    logic prev;
    prev = 1'b0;
    pops = 0;
    for (int i = 0; i < 400 && (model.size() > 0 || out_valid); i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (prev) chk({tag, "_alternate"}, s_ov, 0);
      prev = popd;
      if (popd) pops++;
    end
    #1;
    chk({tag, "_model_empty"}, model.size(), 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_level"}, level, 0);
  endtask

  initial begin
    int v, pops, accepted;
    @(negedge clk);
    do_reset();

    // Push 1,2,3 with out_ready low.
    step(1'b1, 8'd1, 1'b0);
    chk("p1_acc1", acc, 1);
    chk("p1_addr0", s_addr, 0);
    step(1'b1, 8'd2, 1'b0);
    chk("p1_read_blocks_write", s_rdy, 0);
    chk("p1_read_cs", s_cs, 1);
    chk("p1_read_addr", s_addr, 0);
    step(1'b1, 8'd2, 1'b0);
    chk("p1_acc2_addr1", s_addr, 1);
    step(1'b1, 8'd3, 1'b0);
    chk("p1_latency_valid", s_ov, 1);
    chk("p1_latency_data", s_od, 1);
    chk("p1_acc3_addr2", s_addr, 2);
    step(1'b0, 8'd0, 1'b0);
    chk("p1_level", s_level, 3);

    // Pop frees the register: read wins the port, write lands in RD_WAIT.
    step(1'b1, 8'd4, 1'b1);
    chk("p5_in_ready", s_rdy, 0);
    chk("p5_we", s_we, 0);
    chk("p5_cs", s_cs, 1);
    step(1'b1, 8'd4, 1'b1);
    chk("p5_acc_rd_wait", acc, 1);
    drain("p1", pops);

    // Fill to capacity.
    do_reset();
    v = 0;
    for (int i = 0; i < 300 && v < 71; i++) begin
      step(1'b1, 8'(v), 1'b0);
      if (acc) v++;
    end
    chk("p2_accepted", v, 65);
    step(1'b1, 8'd99, 1'b0);
    chk("p2_full_ready", s_rdy, 0);
    chk("p2_full_level", s_level, 65);

    // Drain from full.
    drain("p3", pops);
    chk("p3_pops", pops, 65);

    // Random streaming across pointer wrap.
    accepted = 0;
    for (int i = 0; i < 4000 && accepted < 200; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      if (acc) accepted++;
    end
    chk("p4_accepted", accepted, 200);
    drain("p4", pops);

    // Reset in RD_WAIT discards the pending capture.
    step(1'b1, 8'h3C, 1'b0);
    chk("p6_acc", acc, 1);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    model.delete();
    wr_cnt = 0;
    #1;
    chk("p6_out_valid", out_valid, 0);
    chk("p6_level", level, 0);
    chk("p6_in_ready", in_ready, 1);
    @(negedge clk);
    step(1'b1, 8'hA5, 1'b0);
    chk("p6_acc_a5", acc, 1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    #1;
    chk("p6_a5_valid", out_valid, 1);
    chk("p6_a5_data", out_data, 8'hA5);
    @(negedge clk);
    drain("p6", pops);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
